// File: rtl/ps2_key_event_decoder_if.sv
// Byte-in / event-out handshake bundle for the PS/2 key event decoder.
// slave = decoder side, master = receiver/consumer side.
interface ps2_key_event_decoder_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       ev_repeat;

   modport master (
      output in_valid,
      output in_data,
      output ev_ready,
      input  in_ready,
      input  ev_valid,
      input  ev_code,
      input  ev_ext,
      input  ev_break,
      input  ev_repeat
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  ev_ready,
      output in_ready,
      output ev_valid,
      output ev_code,
      output ev_ext,
      output ev_break,
      output ev_repeat
   );
endinterface

// File: rtl/ps2_key_event_decoder.sv
// Resolves Set-2 E0/F0 prefixes into key events, tracks the held key,
// counts presses/releases and flags protocol errors.
module ps2_key_event_decoder #(
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   ps2_key_event_decoder_if.slave bus,
   output logic                 held_valid,
   output logic [7:0]           held_code,
   output logic                 held_ext,
   output logic [CNT_W-1:0]     press_count,
   output logic [CNT_W-1:0]     release_count,
   output logic                 err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_E0,
      ST_F0,
      ST_E0F0
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t state_q, state_d;
   logic   err_q, err_d;

   logic       ev_valid_q, ev_valid_d;
   logic [7:0] ev_code_q, ev_code_d;
   logic       ev_ext_q, ev_ext_d;
   logic       ev_break_q, ev_break_d;
   logic       ev_repeat_q, ev_repeat_d;

   logic       held_valid_q, held_valid_d;
   logic [7:0] held_code_q, held_code_d;
   logic       held_ext_q, held_ext_d;

   logic [CNT_W-1:0] press_q, press_d;
   logic [CNT_W-1:0] release_q, release_d;

   logic in_ready;
   logic accept;
   logic load;
   logic idle;
   logic is_e0, is_e1, is_f0;
   logic is_stat, is_bad;
   logic new_ext, new_brk;
   logic match;

   // A stalled event blocks byte intake so the prefix state is frozen.
   assign in_ready = !(ev_valid_q && !bus.ev_ready);
   assign accept   = bus.in_valid && in_ready;
   assign idle     = (state_q == ST_IDLE);

   assign is_e0 = (bus.in_data == 8'hE0);
   assign is_e1 = (bus.in_data == 8'hE1);
   assign is_f0 = (bus.in_data == 8'hF0);
   assign is_bad = (bus.in_data == 8'h00) ||
                   (bus.in_data == 8'hFF);
   assign is_stat = (bus.in_data == 8'hAA) ||
                    (bus.in_data == 8'hEE) ||
                    (bus.in_data == 8'hFA) ||
                    (bus.in_data == 8'hFC) ||
                    (bus.in_data == 8'hFE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      load    = 1'b0;
      if (accept) begin
         unique case (1'b1)
            is_e1: begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
            is_e0: begin
               err_d   = err_q | !idle;
               state_d = ST_E0;
            end
            is_f0: begin
               unique case (state_q)
                  ST_IDLE: state_d = ST_F0;
                  ST_E0:   state_d = ST_E0F0;
                  default: err_d   = 1'b1;
               endcase
            end
            idle && is_stat: begin
            end
            idle && is_bad: begin
               err_d = 1'b1;
            end
            default: begin
               load    = 1'b1;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign new_ext = (state_q == ST_E0) || (state_q == ST_E0F0);
   assign new_brk = (state_q == ST_F0) || (state_q == ST_E0F0);
   assign match   = held_valid_q &&
                    (held_code_q == bus.in_data) &&
                    (held_ext_q == new_ext);

   always_comb begin
      ev_valid_d   = ev_valid_q && !bus.ev_ready;
      ev_code_d    = ev_code_q;
      ev_ext_d     = ev_ext_q;
      ev_break_d   = ev_break_q;
      ev_repeat_d  = ev_repeat_q;
      held_valid_d = held_valid_q;
      held_code_d  = held_code_q;
      held_ext_d   = held_ext_q;
      press_d      = press_q;
      release_d    = release_q;
      if (load) begin
         ev_valid_d  = 1'b1;
         ev_code_d   = bus.in_data;
         ev_ext_d    = new_ext;
         ev_break_d  = new_brk;
         ev_repeat_d = !new_brk && match;
         if (new_brk) begin
            release_d = release_q + CNT_ONE;
            if (match) begin
               held_valid_d = 1'b0;
            end
         end else if (!match) begin
            held_valid_d = 1'b1;
            held_code_d  = bus.in_data;
            held_ext_d   = new_ext;
            press_d      = press_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ev_valid_q   <= 1'b0;
         ev_code_q    <= 8'h00;
         ev_ext_q     <= 1'b0;
         ev_break_q   <= 1'b0;
         ev_repeat_q  <= 1'b0;
         held_valid_q <= 1'b0;
         held_code_q  <= 8'h00;
         held_ext_q   <= 1'b0;
         press_q      <= '0;
         release_q    <= '0;
      end else begin
         ev_valid_q   <= ev_valid_d;
         ev_code_q    <= ev_code_d;
         ev_ext_q     <= ev_ext_d;
         ev_break_q   <= ev_break_d;
         ev_repeat_q  <= ev_repeat_d;
         held_valid_q <= held_valid_d;
         held_code_q  <= held_code_d;
         held_ext_q   <= held_ext_d;
         press_q      <= press_d;
         release_q    <= release_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.ev_valid  = ev_valid_q;
   assign bus.ev_code   = ev_code_q;
   assign bus.ev_ext    = ev_ext_q;
   assign bus.ev_break  = ev_break_q;
   assign bus.ev_repeat = ev_repeat_q;

   assign held_valid    = held_valid_q;
   assign held_code     = held_code_q;
   assign held_ext      = held_ext_q;
   assign press_count   = press_q;
   assign release_count = release_q;
   assign err           = err_q;

endmodule
